// File: rtl/dphy_lane_deskew.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dphy_lane_deskew
// Purpose  : Runtime-configurable lane deskew and 32-bit word packer for the
//            D-PHY slave receive path (byte_clk domain, after the per-lane
//            byte aligners). Each lane owns a small buffer that absorbs up to
//            MAX_SKEW cycles of lag against the first valid lane. Skew overrun
//            and lane drops are flagged and the byte aligners are asked to
//            restart their sync search. 1, 2 or 4 active lanes are packed
//            into 32-bit words, earliest byte in [7:0].
// Ports    : byte_clk_i    - byte clock
//            rst_i         - asynchronous active-high reset
//            enable_i      - HS receive enable; low forces IDLE and clears
//            eop_i         - end-of-packet pulse
//            lanes_i       - requested active lane count (1/2/4)
//            byte_data_i   - aligned bytes, lane i at [8i+7:8i]
//            valid_i       - per-lane aligned-byte valid
//            reset_align_o - restart request to the byte aligners
//            data_o        - packed stream word
//            valid_o       - data_o valid, one cycle per word
//            skew_err_o    - one-cycle pulse on skew overrun or lane drop
//            state_o       - FSM state for debug (0 IDLE,1 FILL,2 RUN,3 ERR)
// Revision : 1.0 - initial release
// ============================================================================
module dphy_lane_deskew #(
    parameter int DATA_LANES = 4,
    parameter int MAX_SKEW   = 4
) (
    input  logic                    byte_clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    eop_i,
    input  logic [2:0]              lanes_i,
    input  logic [DATA_LANES*8-1:0] byte_data_i,
    input  logic [DATA_LANES-1:0]   valid_i,
    output logic                    reset_align_o,
    output logic [31:0]             data_o,
    output logic                    valid_o,
    output logic                    skew_err_o,
    output logic [1:0]              state_o
);

    localparam int c_DEPTH = MAX_SKEW + 1;
    localparam int c_PW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_CW    = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Unsupported lane requests fall back to the full physical width.
    function automatic logic [2:0] f_decode(input logic [2:0] req);
        if (req == 3'd1)                       return 3'd1;
        if ((req == 3'd2) && (DATA_LANES >= 2)) return 3'd2;
        if ((req == 3'd4) && (DATA_LANES >= 4)) return 3'd4;
        return 3'(DATA_LANES);
    endfunction

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_lanes;
    logic [2:0]              w_lanes_eff;
    logic [DATA_LANES-1:0]   r_started;
    logic [c_CW-1:0]         r_skew_cnt;
    logic [DATA_LANES-1:0]   w_mask;
    logic [DATA_LANES-1:0]   w_act_valid;
    logic [DATA_LANES-1:0]   w_started_now;
    logic [DATA_LANES-1:0]   w_wr;
    logic                    w_all_valid;
    logic                    w_any_valid;
    logic                    w_pop;
    logic                    w_clear;
    logic [7:0]              w_head [DATA_LANES];
    logic [31:0]             r_acc;
    logic [1:0]              r_beat_cnt;
    logic [31:0]             w_word;
    logic                    w_word_done;
    int                      w_base;

    // In IDLE the lane count is taken straight from the request so the
    // cycle that sees the first valid already uses the new configuration.
    assign w_lanes_eff   = (r_state == ST_IDLE) ? f_decode(lanes_i) : r_lanes;
    assign w_act_valid   = valid_i & w_mask;
    assign w_all_valid   = (w_act_valid == w_mask);
    assign w_any_valid   = |w_act_valid;
    assign w_started_now = r_started | w_act_valid;
    assign w_wr          = (enable_i && (r_state != ST_ERR)) ? w_act_valid : '0;
    // The eop beat still pops, so a word it completes is emitted.
    assign w_pop         = enable_i && (r_state == ST_RUN) && (eop_i || w_all_valid);
    assign w_clear       = (w_next == ST_IDLE) || (w_next == ST_ERR);
    assign state_o       = r_state;

    always_comb begin
        w_next = r_state;
        if (!enable_i) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_all_valid)      w_next = ST_RUN;
                    else if (w_any_valid) w_next = ST_FILL;
                end
                ST_FILL: begin
                    if ((w_started_now & w_mask) == w_mask)
                        w_next = ST_RUN;
                    // A lane still missing now would lag by more than MAX_SKEW.
                    else if (r_skew_cnt == c_CW'(MAX_SKEW - 1))
                        w_next = ST_ERR;
                end
                ST_RUN: begin
                    if (eop_i)             w_next = ST_IDLE;
                    else if (!w_all_valid) w_next = ST_ERR;
                end
                ST_ERR: begin
                    if (valid_i == '0) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_lanes       <= 3'(DATA_LANES);
            r_started     <= '0;
            r_skew_cnt    <= '0;
            reset_align_o <= 1'b0;
            skew_err_o    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE)
                r_lanes <= f_decode(lanes_i);
            r_started  <= (w_next == ST_FILL) ? w_started_now : '0;
            r_skew_cnt <= ((r_state == ST_FILL) && (w_next == ST_FILL))
                          ? r_skew_cnt + 1'b1 : '0;
            reset_align_o <= !enable_i || (w_next == ST_ERR)
                             || ((r_state == ST_RUN) && eop_i);
            skew_err_o    <= (w_next == ST_ERR) && (r_state != ST_ERR);
        end
    end

    // Per-lane deskew buffers. In RUN each lane writes and pops once per
    // cycle, so the head of every buffer holds the same stream position.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_LANES; gi++) begin : g_lane
            logic [7:0]      r_mem [c_DEPTH];
            logic [c_PW-1:0] r_wptr;
            logic [c_PW-1:0] r_rptr;

            assign w_mask[gi] = (gi < int'(w_lanes_eff));
            assign w_head[gi] = r_mem[r_rptr];

            always_ff @(posedge byte_clk_i) begin
                if (w_wr[gi])
                    r_mem[r_wptr] <= byte_data_i[8*gi +: 8];
            end

            always_ff @(posedge byte_clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else if (w_clear) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_wr[gi])
                        r_wptr <= (r_wptr == c_PW'(c_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
                    if (w_pop)
                        r_rptr <= (r_rptr == c_PW'(c_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
                end
            end
        end
    endgenerate

    // Beat k of a word lands at bytes [k*L .. k*L+L-1].
    always_comb begin
        w_word = r_acc;
        w_base = int'(r_beat_cnt) * int'(r_lanes);
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < DATA_LANES; j++) begin
                if ((j < int'(r_lanes)) && (b == w_base + j))
                    w_word[8*b +: 8] = w_head[j];
            end
        end
    end

    assign w_word_done = ((int'(r_beat_cnt) + 1) * int'(r_lanes)) == 4;

    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (w_pop && w_word_done) begin
                data_o  <= w_word;
                valid_o <= 1'b1;
            end
            // A partial word left when the stream ends is dropped.
            if (w_clear || (w_pop && w_word_done)) begin
                r_beat_cnt <= '0;
            end else if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_acc      <= w_word;
            end
        end
    end

endmodule
`default_nettype wire
